// File: rtl/dwt_pkg.sv
// Shared definitions for the 5/3 lifting DWT controller: FSM state encoding and default sizes.
package dwt_pkg;

  localparam int DWT_DW        = 8;
  localparam int DWT_FRAME_LEN = 8;
  localparam int DWT_CW        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dwt_state_t;

endpackage

// File: rtl/dwt_lift_core.sv
// Combinational predict/update lifting step for one (s,d) pair.
// DWT_SYM_EXT_EN selects symmetric boundary extension; otherwise zero extension.
module dwt_lift_core
  import dwt_pkg::*;
#(
  parameter int DW = DWT_DW
) (
  input  logic [DW-1:0] i_x_even,
  input  logic [DW-1:0] i_x_odd,
  input  logic [DW-1:0] i_x_next,
  input  logic [DW-1:0] i_d_prev,
  input  logic          i_first,
  input  logic          i_last,
  output logic [DW-1:0] o_s,
  output logic [DW-1:0] o_d
);

  logic [DW-1:0] w_x_next;
  logic [DW-1:0] w_d_prev;
  logic [DW-1:0] w_d;
  logic [DW:0]   w_pred_sum;
  logic [DW:0]   w_upd_sum;

  // On the last pair i_x_even already holds x[FRAME_LEN-2], the mirrored sample.
`ifdef DWT_SYM_EXT_EN
  assign w_x_next = i_last  ? i_x_even : i_x_next;
  assign w_d_prev = i_first ? w_d      : i_d_prev;
`else
  assign w_x_next = i_last  ? '0 : i_x_next;
  assign w_d_prev = i_first ? '0 : i_d_prev;
`endif

  assign w_pred_sum = {1'b0, i_x_even} + {1'b0, w_x_next};
  assign w_d        = i_x_odd - DW'(w_pred_sum >> 1);
  assign w_upd_sum  = {1'b0, w_d_prev} + {1'b0, w_d};

  assign o_d = w_d;
  assign o_s = i_x_even + DW'(w_upd_sum >> 2);

endmodule

// File: rtl/dwt_lift_ctrl.sv
// Frame controller for a streaming 5/3 lifting DWT: sample intake, pair history and one output register.
// Boundary handling follows DWT_SYM_EXT_EN inside dwt_lift_core.
module dwt_lift_ctrl
  import dwt_pkg::*;
#(
  parameter int DW        = DWT_DW,
  parameter int FRAME_LEN = DWT_FRAME_LEN,
  parameter int CW        = DWT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_s,
  output logic [DW-1:0] out_d,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done,
  output dwt_state_t    o_dbg_state
);

  localparam logic [CW-1:0] LAST_PAIR = CW'(FRAME_LEN / 2 - 1);

  dwt_state_t    r_state;
  logic [CW-1:0] r_pair;
  logic          r_odd;
  logic [DW-1:0] r_x_even;
  logic [DW-1:0] r_x_odd;
  logic [DW-1:0] r_d_prev;
  logic          r_out_valid;
  logic [DW-1:0] r_out_s;
  logic [DW-1:0] r_out_d;
  logic          r_out_last;
  logic          r_frame_done;

  logic          w_out_free;
  logic          w_accept;
  logic          w_first;
  logic          w_flush;
  logic [DW-1:0] w_core_s;
  logic [DW-1:0] w_core_d;

  // Both ports: a beat transfers on a rising edge where valid && ready; valid never
  // depends on ready, and payload stays stable while valid is high and ready is low.
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == ST_RUN) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_flush    = (r_state == ST_FLUSH);
  // Next sample index is 2*r_pair + r_odd, so an even arrival with r_pair==1 closes pair 0.
  assign w_first    = (r_state == ST_RUN) && (r_pair == CW'(1));

  dwt_lift_core #(.DW(DW)) u_core (
    .i_x_even (r_x_even),
    .i_x_odd  (r_x_odd),
    .i_x_next (in_data),
    .i_d_prev (r_d_prev),
    .i_first  (w_first),
    .i_last   (w_flush),
    .o_s      (w_core_s),
    .o_d      (w_core_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pair       <= '0;
      r_odd        <= 1'b0;
      r_x_even     <= '0;
      r_x_odd      <= '0;
      r_d_prev     <= '0;
      r_out_valid  <= 1'b0;
      r_out_s      <= '0;
      r_out_d      <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_RUN;
            r_pair   <= '0;
            r_odd    <= 1'b0;
            r_x_even <= '0;
            r_x_odd  <= '0;
            r_d_prev <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (!r_odd) begin
              r_x_even <= in_data;
              r_odd    <= 1'b1;
              if (r_pair != '0) begin
                r_out_valid <= 1'b1;
                r_out_s     <= w_core_s;
                r_out_d     <= w_core_d;
                r_out_last  <= 1'b0;
                r_d_prev    <= w_core_d;
              end
            end else begin
              r_x_odd <= in_data;
              r_odd   <= 1'b0;
              if (r_pair == LAST_PAIR) r_state <= ST_FLUSH;
              else                     r_pair  <= r_pair + CW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_s     <= w_core_s;
            r_out_d     <= w_core_d;
            r_out_last  <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_frame_done)                   r_state      <= ST_IDLE;
          else if (r_out_valid && out_ready)  r_frame_done <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_s       = r_out_s;
  assign out_d       = r_out_d;
  assign out_last    = r_out_last;
  assign frame_done  = r_frame_done;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dwt_lift_ctrl.sv
// Self-checking bench for dwt_lift_ctrl: directed golden frames, backpressure, wrap-around,
// abort on reset and randomized frames against a lifting-equation reference model.
module tb_dwt_lift_ctrl;
  import dwt_pkg::*;

  localparam int DW        = 8;
  localparam int FRAME_LEN = 8;
  localparam int CW        = 4;
  localparam int NP        = FRAME_LEN / 2;
  localparam int MASK      = (1 << DW) - 1;
`ifdef DWT_SYM_EXT_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_s;
  logic [DW-1:0] out_d;
  logic          out_last;
  logic          busy;
  logic          frame_done;
  dwt_state_t    dbg_state;

  int checks = 0;
  int failures = 0;
  int pairs_seen = 0;
  int fd_cnt = 0;
  bit mon_en = 1'b0;
  int xs [FRAME_LEN];
  logic [2*DW:0] exp_q [$];
  logic [2*DW:0] held;
  bit held_v = 1'b0;

  dwt_lift_ctrl #(.DW(DW), .FRAME_LEN(FRAME_LEN), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_d      (out_d),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: lifting equations with plain integer arithmetic
  task automatic model_frame();
    int d [NP];
    int xn, dp, s;
    logic [DW-1:0] sv, dv;
    for (int k = 0; k < NP; k++) begin
      if (2*k + 2 < FRAME_LEN) xn = xs[2*k+2];
      else                     xn = SYM ? xs[FRAME_LEN-2] : 0;
      d[k] = (xs[2*k+1] - ((xs[2*k] + xn) / 2)) & MASK;
    end
    for (int k = 0; k < NP; k++) begin
      if (k == 0) dp = SYM ? d[0] : 0;
      else        dp = d[k-1];
      s  = (xs[2*k] + ((dp + d[k]) / 4)) & MASK;
      sv = DW'(s);
      dv = DW'(d[k]);
      exp_q.push_back({(k == NP-1), sv, dv});
    end
  endtask

  task automatic load_directed();
    int v [FRAME_LEN] = '{10, 40, 20, 50, 30, 60, 28, 46};
    for (int i = 0; i < FRAME_LEN; i++) xs[i] = v[i];
  endtask

  task automatic push_golden();
`ifdef DWT_SYM_EXT_EN
    exp_q.push_back({1'b0, 8'd22, 8'd25});
    exp_q.push_back({1'b0, 8'd32, 8'd25});
    exp_q.push_back({1'b0, 8'd44, 8'd31});
    exp_q.push_back({1'b1, 8'd40, 8'd18});
`else
    exp_q.push_back({1'b0, 8'd16, 8'd25});
    exp_q.push_back({1'b0, 8'd32, 8'd25});
    exp_q.push_back({1'b0, 8'd44, 8'd31});
    exp_q.push_back({1'b1, 8'd43, 8'd32});
`endif
  endtask

  // scoreboard / output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && held_v) chk("hold_stable", {out_last, out_s, out_d}, held);
      if (out_valid && out_ready) begin
        chk("pair_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("pair", {out_last, out_s, out_d}, exp_q.pop_front());
        pairs_seen++;
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      held_v = out_valid && !out_ready;
      held   = {out_last, out_s, out_d};
      if (frame_done) fd_cnt++;
    end else begin
      held_v = 1'b0;
    end
  end

  // mode 0: ready always; 1: random valid/ready; 2: 5-cycle stall while pair 1 is presented
  task automatic run_frame(input int mode, input bit poke);
    int idx, cyc, stall_left;
    bit stalled, acc, fin;
    fd_cnt = 0; pairs_seen = 0; idx = 0; cyc = 0;
    stall_left = 0; stalled = 0; fin = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    while (!fin && cyc < 400) begin
      if (frame_done) begin
        chk("fd_busy", busy, 1);
        start = poke; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_drop", busy, 0);
        chk("fd_pulse", frame_done, 0);
        chk("state_idle", dbg_state, ST_IDLE);
        fin = 1;
      end else begin
        in_valid = (idx < FRAME_LEN) && (mode != 1 || $urandom_range(0, 3) != 0);
        in_data  = in_valid ? DW'(xs[idx]) : DW'($urandom_range(0, MASK));
        if (mode == 2 && !stalled && pairs_seen == 1 && out_valid) begin
          stalled = 1; stall_left = 5;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        start = poke && (cyc == 3);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) begin
          if (idx % 2 == 0 && idx >= 2) chk("latency1", out_valid, 1);
          idx++;
        end
        cyc++;
      end
    end
    chk("frame_in_budget", fin, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    if (mode == 2) chk("stall_happened", stalled, 1);
    chk("pairs_count", pairs_seen, NP);
    chk("queue_empty", exp_q.size(), 0);
    chk("fd_once", fd_cnt, 1);
    exp_q.delete();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_d", out_d, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // directed golden frame
    load_directed(); push_golden();
    run_frame(0, 0);

    // directed frame checked through the model as well, with backpressure at pair 1
    load_directed(); model_frame();
    run_frame(2, 0);

    // wrap-around
    for (int i = 0; i < FRAME_LEN; i++) xs[i] = (i % 2 == 0) ? MASK : 0;
    model_frame();
    run_frame(0, 0);

    // randomized frames, one with start pokes during RUN and on frame_done
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) xs[i] = $urandom_range(0, MASK);
      model_frame();
      run_frame((f == 3) ? 2 : 1, (f == 1));
    end

    // abort mid-RUN after three samples
    mon_en = 1'b0; exp_q.delete();
    load_directed();
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(xs[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("abort_pair0_loaded", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_s", out_s, 0);
    chk("abort_out_d", out_d, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_in_ready", in_ready, 0);
      chk("post_abort_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mon_en = 1'b1;
    push_golden();
    run_frame(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
